instr_fetch: RTL
================

# instr_fetch

Instruction fetch stage of the MIPS-32 core, directly upstream of `ControlUnit`. It owns the program counter, issues word reads to instruction memory through a req/ready handshake, and holds the fetched instruction in an output register. It slices that instruction into the opcode/funct/register/immediate fields consumed by `ControlUnit` and the register file. It resolves `j`/`jal` itself and takes branch/`jr` redirects from downstream; the core has no branch delay slots.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: read request; address must be held stable while high and `imem_ready` low.
- `imem_addr` out 32: word address (bits [1:0] always 0).
- `imem_ready` in 1: read completes this cycle; `imem_rdata` valid.
- `imem_rdata` in 32: instruction word.
- `out_valid` out 1: output register holds a valid instruction.
- `out_ready` in 1: downstream accepts; transfer when `out_valid && out_ready`.
- `redirect` in 1: branch taken or `jr`; flush and restart at `redirect_pc`.
- `redirect_pc` in 32: restart address.
- `instr` out 32: output register.
- `pc_out` out 32: address of `instr`.
- `pc_plus4` out 32: `pc_out + 4`, the link value for `jal`.
- `opcode` out 6 = `instr[31:26]`; `funct` out 6 = `instr[5:0]`; `rs` out 5 = `[25:21]`; `rt` out 5 = `[20:16]`; `rd` out 5 = `[15:11]`; `shamt` out 5 = `[10:6]`; `imm` out 16 = `[15:0]`.
- `addr_err` out 1: sticky; set by a misaligned `redirect_pc`.

## Operation
- Reset: `pc = RESET_PC`, `out_valid = 0`, `instr = 0` (so all field outputs are 0), `pc_out = 0`, `addr_err = 0`, state RUN. `imem_req = 0` while `reset` is high.
- RUN state:
  - `imem_req = !out_valid || out_ready`; `imem_addr = pc`.
  - On `imem_req && imem_ready`: `instr <= imem_rdata`, `pc_out <= pc`, `out_valid <= 1`.
  - Next PC: if `imem_rdata[31:26]` is 000010 (`j`) or 000011 (`jal`), `pc <= {pc_plus[31:28], imem_rdata[25:0], 2'b00}` with `pc_plus = pc + 4`. Otherwise `pc <= pc + 4`, wrapping modulo 2^32.
  - On transfer with no capture in the same cycle: `out_valid <= 0`.
- Redirect, which has priority over every other update:
  - `out_valid <= 0` (the wrong-path instruction is dropped even if it transfers in that cycle).
  - Target is `{redirect_pc[31:2], 2'b00}`. If `redirect_pc[1:0] != 0`, set `addr_err`.
  - If no request is pending, or `imem_ready` is high in the same cycle: `pc <= target`, any returned data is discarded, stay in RUN.
  - If `imem_req && !imem_ready`: save the target, go to DISCARD.
- DISCARD state:
  - `imem_req = 1` with the old `imem_addr` held.
  - On `imem_ready`: data discarded, `pc <= saved target`, go to RUN.
  - A further redirect while in DISCARD overwrites the saved target (latest wins). `out_valid` stays 0.
- Reset in any state, including DISCARD, returns to the reset values next cycle. An abandoned memory request is the memory's concern.

## Timing
- Latency: instruction is visible on `instr` and the field outputs one cycle after the cycle in which `imem_ready` is high.
- With zero-wait memory and `out_ready` held high, throughput is one instruction per cycle.
- Output register holds stable while `out_valid && !out_ready`; `imem_req` stays low during that time.
- Redirect to the first request at the target address: next cycle in RUN; one cycle after `imem_ready` in DISCARD.
- `j`/`jal` cost no bubble: the next request goes to the jump target.

## Test plan
- Reset, `RESET_PC=0`, zero-wait memory returning `0x20080005` (addi): `imem_addr` sequence 0, 4, 8; `instr` valid cycle 2 with `opcode=001000`, `rt=8`, `imm=5`, `pc_plus4=4`.
- `j` at `0x0000_0010` with `rdata=0x08000040`: next `imem_addr=0x0000_0100`; fetch at 0x14 never issued.
- `out_ready=0` for 3 cycles while `out_valid=1`: `instr` and `pc_out` unchanged, `imem_req=0`; on release, the next fetch issues the same cycle.
- Memory with 2 wait states; `redirect=1`, `redirect_pc=0x40` in the first wait cycle: `imem_addr` held until `imem_ready`, data discarded, next request at 0x40, `out_valid` stays 0 throughout.
- `redirect_pc=0x43`: `imem_addr=0x40` and `addr_err=1`, which stays 1 until reset.
- Reset asserted during DISCARD: next cycle `out_valid=0`, `addr_err=0`, `imem_addr=RESET_PC` once reset is released.

Source files
------------

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS-32 instruction fetch stage: PC, imem handshake, output register, field slicing
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic        addr_err
);

  typedef enum logic {RUN, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] saved_pc;
  logic [31:0] pc_plus;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        fire;

  // DISCARD keeps the abandoned request alive so the memory sees a stable address until it completes
  assign imem_req  = !reset && ((state == DISCARD) || !out_valid || out_ready);
  assign imem_addr = pc;
  assign fire      = imem_req && imem_ready;
  assign pc_plus   = pc + 32'd4;
  assign target    = {redirect_pc[31:2], 2'b00};

  // j (000010) and jal (000011) resolve here so the next request already goes to the target
  assign next_pc = (imem_rdata[31:27] == 5'b00001) ? {pc_plus[31:28], imem_rdata[25:0], 2'b00}
                                                  : pc_plus;

  assign pc_plus4 = pc_out + 32'd4;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      saved_pc  <= RESET_PC;
      instr     <= 32'h0;
      pc_out    <= 32'h0;
      out_valid <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      if (redirect && (redirect_pc[1:0] != 2'b00)) addr_err <= 1'b1;
      if (state == RUN) begin
        if (redirect) begin
          out_valid <= 1'b0;
          if (imem_req && !imem_ready) begin
            saved_pc <= target;
            state    <= DISCARD;
          end else begin
            pc <= target;
          end
        end else if (fire) begin
          instr     <= imem_rdata;
          pc_out    <= pc;
          out_valid <= 1'b1;
          pc        <= next_pc;
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end else begin
        if (redirect) saved_pc <= target;
        if (imem_ready) begin
          pc    <= redirect ? target : saved_pc;
          state <= RUN;
        end
      end
    end
  end

endmodule
